// File: rtl/boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : boot_ctrl
//  Brief    : UART boot sequencer. Parses a framed program image from the
//             received byte stream, writes it into instruction memory, checks
//             the 8-bit data checksum, and releases the CPU reset only after
//             a good load.
//  Revision : 1.0 - initial release
// ============================================================================
module boot_ctrl #(
    parameter int          ADDR_WIDTH     = 12,
    parameter int          TIMEOUT_CYCLES = 4800000,
    parameter logic [7:0]  MAGIC          = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  boot_req,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_RUN  = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam int                c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    // Largest accepted word count: the full instruction memory
    localparam logic [16:0]       c_MAX_LEN  = 17'(1 << ADDR_WIDTH);
    // Word index needs one extra bit so a full-memory image can be counted
    localparam int                c_WI_W     = ADDR_WIDTH + 1;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nx;
    logic [15:0]           r_len;
    logic [c_WI_W-1:0]     r_widx;
    logic [1:0]            r_bidx;
    logic [7:0]            r_sum;
    logic [31:0]           r_word;
    logic [c_TMO_W-1:0]    r_tmo;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_cpu_rst;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic                  w_cpu_rst_nx;
    logic                  w_busy_nx;
    logic                  w_done_nx;
    logic                  w_error_nx;

    logic                  w_in_frame;
    logic                  w_tmo_hit;
    logic [15:0]           w_len_full;
    logic                  w_len_bad;
    logic                  w_last_word;
    logic [31:0]           w_word_shift;

    assign w_in_frame   = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                          (r_state == S_DATA) || (r_state == S_CSUM);
    // A byte arriving on the expiry cycle keeps the frame alive
    assign w_tmo_hit    = w_in_frame && !rx_valid && (r_tmo == c_TMO_LAST);
    assign w_len_full   = {rx_data, r_len[7:0]};
    assign w_len_bad    = {1'b0, w_len_full} > c_MAX_LEN;
    assign w_last_word  = (17'(r_widx) + 17'd1) == {1'b0, r_len};
    // Bytes arrive LSB first, so new bytes enter at the top and slide down
    assign w_word_shift = {rx_data, r_word[31:8]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode: frame parsing, then timeout, then boot_req override
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_valid && (rx_data == MAGIC)) w_state_nx = S_LEN0;
            end
            S_LEN0: begin
                if (rx_valid) w_state_nx = S_LEN1;
            end
            S_LEN1: begin
                if (rx_valid) begin
                    if (w_len_bad)               w_state_nx = S_ERR;
                    else if (w_len_full == 16'd0) w_state_nx = S_CSUM;
                    else                          w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_valid && (r_bidx == 2'd3) && w_last_word) w_state_nx = S_CSUM;
            end
            S_CSUM: begin
                if (rx_valid) w_state_nx = (rx_data == r_sum) ? S_RUN : S_ERR;
            end
            S_RUN: begin
                w_state_nx = S_RUN;
            end
            S_ERR: begin
                if (rx_valid && (rx_data == MAGIC)) w_state_nx = S_LEN0;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        if (w_tmo_hit) w_state_nx = S_ERR;
        if (boot_req)  w_state_nx = S_IDLE;
    end

    // Status outputs decoded from the state being entered
    always_comb begin
        w_cpu_rst_nx = (w_state_nx != S_RUN);
        w_done_nx    = (w_state_nx == S_RUN);
        w_error_nx   = (w_state_nx == S_ERR);
        w_busy_nx    = (w_state_nx == S_LEN0) || (w_state_nx == S_LEN1) ||
                       (w_state_nx == S_DATA) || (w_state_nx == S_CSUM);
    end

    // Status output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_cpu_rst <= w_cpu_rst_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_error   <= w_error_nx;
        end
    end

    // Frame datapath: length latch, word assembly, checksum, timeout, writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= '0;
            r_widx  <= '0;
            r_bidx  <= '0;
            r_sum   <= '0;
            r_word  <= '0;
            r_tmo   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (boot_req) begin
            r_widx  <= '0;
            r_bidx  <= '0;
            r_sum   <= '0;
            r_word  <= '0;
            r_tmo   <= '0;
            r_we    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (rx_valid || !w_in_frame || w_tmo_hit) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (rx_valid) begin
                case (r_state)
                    S_LEN0: begin
                        r_len[7:0] <= rx_data;
                    end
                    S_LEN1: begin
                        r_len[15:8] <= rx_data;
                        r_widx      <= '0;
                        r_bidx      <= '0;
                        r_sum       <= '0;
                        r_word      <= '0;
                    end
                    S_DATA: begin
                        r_sum  <= r_sum + rx_data;
                        r_word <= w_word_shift;
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_widx[ADDR_WIDTH-1:0];
                            r_wdata <= w_word_shift;
                            r_widx  <= r_widx + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boot_ctrl
//  Brief    : Self-checking bench for boot_ctrl. A byte-position frame model
//             predicts every output each cycle; directed frames pin exact
//             write contents and status, then randomized frames follow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_boot_ctrl;

    localparam int         AW    = 12;
    localparam int         TMO   = 100;
    localparam logic [7:0] MAGIC = 8'hA5;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          boot_req;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          error;

    boot_ctrl #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO),
        .MAGIC          (MAGIC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .boot_req   (boot_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Frame model: position of the next expected byte within the frame
    bit          m_in   = 1'b0;
    bit          m_run  = 1'b0;
    bit          m_err  = 1'b0;
    int          m_pos  = 0;
    int          m_len  = 0;
    int          m_idle = 0;
    logic [7:0]  m_lenlo = '0;
    logic [7:0]  m_sum  = '0;
    logic [31:0] m_buf  = '0;
    bit          m_we   = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_wdata = '0;

    // Writes observed on the DUT
    int          wa[$];
    logic [31:0] wd[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in = 0; m_run = 0; m_err = 0; m_pos = 0; m_idle = 0; m_we = 0;
    endtask

    task automatic model_step(input bit rxv, input logic [7:0] rxd, input bit breq);
        int k;
        m_we = 0;
        if (breq) begin
            m_in = 0; m_run = 0; m_err = 0; m_idle = 0;
        end else if (m_in) begin
            if (rxv) begin
                m_idle = 0;
                if (m_pos == 1) begin
                    m_lenlo = rxd;
                    m_pos = 2;
                end else if (m_pos == 2) begin
                    m_len = int'(rxd) * 256 + int'(m_lenlo);
                    if (m_len > (1 << AW)) begin
                        m_in = 0; m_err = 1;
                    end else begin
                        m_sum = 0; m_pos = 3;
                    end
                end else if (m_pos < 3 + 4 * m_len) begin
                    k = m_pos - 3;
                    m_sum = m_sum + rxd;
                    m_buf[8*(k%4) +: 8] = rxd;
                    if (k % 4 == 3) begin
                        m_we = 1; m_addr = k / 4; m_wdata = m_buf;
                    end
                    m_pos++;
                end else begin
                    m_in = 0;
                    if (rxd == m_sum) m_run = 1;
                    else              m_err = 1;
                end
            end else begin
                m_idle++;
                if (m_idle >= TMO) begin
                    m_in = 0; m_err = 1;
                end
            end
        end else if (!m_run) begin
            if (rxv && rxd == MAGIC) begin
                m_in = 1; m_err = 0; m_pos = 1; m_idle = 0;
            end
        end
    endtask

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        chk("cpu_rst", 32'(cpu_rst), 32'(!m_run));
        chk("busy",    32'(busy),    32'(m_in));
        chk("done",    32'(done),    32'(m_run));
        chk("error",   32'(error),   32'(m_err));
        chk("imem_we", 32'(imem_we), 32'(m_we));
        if (m_we) begin
            chk("imem_addr",  32'(imem_addr), 32'(m_addr));
            chk("imem_wdata", imem_wdata,     m_wdata);
        end
        if (imem_we) begin
            wa.push_back(int'(imem_addr));
            wd.push_back(imem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_step(rx_valid, rx_data, boot_req);
        rx_valid = 1'b0;
        boot_req = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int maxgap, input bit rnd_breq);
        rx_valid = 1'b1;
        rx_data  = b;
        if (rnd_breq && $urandom_range(0, 59) == 0) boot_req = 1'b1;
        tick();
        repeat ($urandom_range(0, maxgap)) tick();
    endtask

    // Sends a frame; the final byte is followed by no gap so status can be checked at once
    task automatic send_frame(input logic [7:0] fb[$], input int maxgap);
        for (int i = 0; i < fb.size(); i++) begin
            send(fb[i], (i == fb.size() - 1) ? 0 : maxgap, 1'b0);
        end
    endtask

    task automatic do_boot_req();
        boot_req = 1'b1;
        tick();
    endtask

    logic [7:0] good_frame[$] = '{8'hA5, 8'h02, 8'h00,
                                  8'h78, 8'h56, 8'h34, 8'h12,
                                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    logic [7:0] bad_frame[$]  = '{8'hA5, 8'h02, 8'h00,
                                  8'h78, 8'h56, 8'h34, 8'h12,
                                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h53};
    logic [7:0] zero_frame[$] = '{8'hA5, 8'h00, 8'h00, 8'h00};

    task automatic check_two_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk({tag, "_a0"}, 32'(wa[0]), 32'd0);
            chk({tag, "_d0"}, wd[0], 32'h12345678);
            chk({tag, "_a1"}, 32'(wa[1]), 32'd1);
            chk({tag, "_d1"}, wd[1], 32'hDEADBEEF);
        end
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] csum;
        int         len;

        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; boot_req = 1'b0;
        repeat (3) tick();
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_we",      32'(imem_we), 32'd0);
        rst = 1'b0;
        tick();

        // Normal two-word load
        wa.delete(); wd.delete();
        send_frame(good_frame, 2);
        check_two_writes("good");
        chk("good_done",    32'(done),    32'd1);
        chk("good_cpu_rst", 32'(cpu_rst), 32'd0);

        // Bytes are ignored while the CPU runs, boot_req drops back to reset
        send(MAGIC, 1, 1'b0);
        send(8'h00, 1, 1'b0);
        chk("run_ignore_done", 32'(done), 32'd1);
        do_boot_req();
        chk("breq_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("breq_done",    32'(done),    32'd0);

        // Bad checksum still writes, then errors; zero-length frame recovers
        wa.delete(); wd.delete();
        send_frame(bad_frame, 2);
        check_two_writes("bad");
        chk("bad_error",   32'(error),   32'd1);
        chk("bad_cpu_rst", 32'(cpu_rst), 32'd1);
        send_frame(zero_frame, 2);
        chk("zero_done",  32'(done),       32'd1);
        chk("zero_error", 32'(error),      32'd0);
        chk("zero_nwr",   32'(wa.size()),  32'd2);

        // Length overflow and the exact-capacity boundary
        do_boot_req();
        wa.delete(); wd.delete();
        fr = '{8'hA5, 8'h01, 8'h10};
        send_frame(fr, 1);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_busy",  32'(busy),  32'd0);
        fr = '{8'hA5, 8'h00, 8'h10};
        send_frame(fr, 1);
        chk("maxlen_busy",  32'(busy),  32'd1);
        chk("maxlen_error", 32'(error), 32'd0);

        // Inter-byte timeout mid-data
        do_boot_req();
        fr = '{8'hA5, 8'h01, 8'h00, 8'h78};
        send_frame(fr, 1);
        repeat (TMO - 1) tick();
        chk("tmo_early_err",  32'(error), 32'd0);
        chk("tmo_early_busy", 32'(busy),  32'd1);
        tick();
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_busy",  32'(busy),  32'd0);
        chk("tmo_nwr",   32'(wa.size()), 32'd0);

        // Asynchronous reset in the middle of the data phase
        do_boot_req();
        fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
        send_frame(fr, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_cpu_rst", 32'(cpu_rst),    32'd1);
        chk("arst_busy",    32'(busy),       32'd0);
        chk("arst_we",      32'(imem_we),    32'd0);
        chk("arst_addr",    32'(imem_addr),  32'd0);
        chk("arst_wdata",   imem_wdata,      32'd0);
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        wa.delete(); wd.delete();
        send_frame(good_frame, 1);
        check_two_writes("fresh");
        chk("fresh_done", 32'(done), 32'd1);

        // Randomized frames against the model
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 1) == 1) do_boot_req();
            repeat ($urandom_range(0, 3)) send(8'($urandom_range(0, 255)), 2, 1'b1);
            len  = $urandom_range(1, 4);
            fr   = '{MAGIC, 8'(len), 8'h00};
            csum = '0;
            for (int i = 0; i < 4 * len; i++) begin
                fr.push_back(8'($urandom));
                csum = csum + fr[fr.size() - 1];
            end
            if ($urandom_range(0, 3) == 0) csum = csum + 8'(1 + $urandom_range(0, 254));
            fr.push_back(csum);
            if ($urandom_range(0, 7) == 0) begin
                // Truncated frame left to time out
                for (int i = 0; i < 5; i++) send(fr[i], 2, 1'b0);
                repeat (TMO + 3) tick();
            end else begin
                for (int i = 0; i < fr.size(); i++) send(fr[i], 2, 1'b1);
            end
            repeat (2) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
